// File: rtl/exe_stage_unit.sv
// Execute stage: ID/EX pipeline register, 32-bit ALU with NZCV status,
// branch target resolution and the EX/MEM register feeding the memory stage.
module exe_stage_unit #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_stall,
    input  logic                  flush,
    input  logic                  hazard_bubble,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read_en,
    input  logic                  id_mem_write_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [3:0]            id_exe_cmd,
    input  logic [WIDTH-1:0]      id_pc,
    input  logic [WIDTH-1:0]      id_val_rn,
    input  logic [WIDTH-1:0]      id_val2,
    input  logic [WIDTH-1:0]      id_val_rm,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [23:0]           id_imm24,
    output logic                  exe_wb_en,
    output logic                  exe_mem_read_en,
    output logic                  exe_mem_write_en,
    output logic [WIDTH-1:0]      exe_alu_res,
    output logic [WIDTH-1:0]      exe_st_val,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic                  branch_taken,
    output logic [WIDTH-1:0]      branch_addr,
    output logic [3:0]            status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam int         MSB     = WIDTH - 1;

    logic                  idex_wb_en;
    logic                  idex_mem_read_en;
    logic                  idex_mem_write_en;
    logic                  idex_b;
    logic                  idex_s;
    logic [3:0]            idex_exe_cmd;
    logic [WIDTH-1:0]      idex_pc;
    logic [WIDTH-1:0]      idex_val_rn;
    logic [WIDTH-1:0]      idex_val2;
    logic [WIDTH-1:0]      idex_val_rm;
    logic [REG_ADDR_W-1:0] idex_dest;
    logic [23:0]           idex_imm24;

    logic [WIDTH-1:0]      alu_res;
    logic [WIDTH:0]        sum;
    logic                  carry_out;
    logic                  overflow;
    logic                  flag_valid;
    logic                  carry_in;
    logic                  status_we;
    logic [WIDTH-1:0]      branch_offset;

    // A bubble only zeroes control; data fields are loaded anyway since
    // nothing downstream looks at them without a control bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_wb_en        <= 1'b0;
            idex_mem_read_en  <= 1'b0;
            idex_mem_write_en <= 1'b0;
            idex_b            <= 1'b0;
            idex_s            <= 1'b0;
            idex_exe_cmd      <= '0;
            idex_pc           <= '0;
            idex_val_rn       <= '0;
            idex_val2         <= '0;
            idex_val_rm       <= '0;
            idex_dest         <= '0;
            idex_imm24        <= '0;
        end else if (!mem_stall) begin
            idex_exe_cmd <= id_exe_cmd;
            idex_pc      <= id_pc;
            idex_val_rn  <= id_val_rn;
            idex_val2    <= id_val2;
            idex_val_rm  <= id_val_rm;
            idex_dest    <= id_dest;
            idex_imm24   <= id_imm24;
            if (flush || hazard_bubble) begin
                idex_wb_en        <= 1'b0;
                idex_mem_read_en  <= 1'b0;
                idex_mem_write_en <= 1'b0;
                idex_b            <= 1'b0;
                idex_s            <= 1'b0;
            end else begin
                idex_wb_en        <= id_wb_en;
                idex_mem_read_en  <= id_mem_read_en;
                idex_mem_write_en <= id_mem_write_en;
                idex_b            <= id_b;
                idex_s            <= id_s;
            end
        end
    end

    assign carry_in = status[1];

    // Subtraction is done as rn + ~val2 + 1 so the carry out is already NOT borrow.
    always_comb begin
        alu_res    = '0;
        sum        = '0;
        carry_out  = status[1];
        overflow   = status[0];
        flag_valid = 1'b1;
        case (idex_exe_cmd)
            CMD_MOV: alu_res = idex_val2;
            CMD_MVN: alu_res = ~idex_val2;
            CMD_AND: alu_res = idex_val_rn & idex_val2;
            CMD_ORR: alu_res = idex_val_rn | idex_val2;
            CMD_EOR: alu_res = idex_val_rn ^ idex_val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, idex_val_rn} + {1'b0, idex_val2}
                    + (WIDTH+1)'((idex_exe_cmd == CMD_ADC) ? carry_in : 1'b0);
                alu_res   = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (idex_val_rn[MSB] == idex_val2[MSB]) &&
                            (alu_res[MSB] != idex_val_rn[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, idex_val_rn} + {1'b0, ~idex_val2}
                    + (WIDTH+1)'((idex_exe_cmd == CMD_SBC) ? carry_in : 1'b1);
                alu_res   = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (idex_val_rn[MSB] != idex_val2[MSB]) &&
                            (alu_res[MSB] != idex_val_rn[MSB]);
            end
            default: flag_valid = 1'b0;
        endcase
    end

    // On loads/stores the S bit selects load vs store, so it must not write flags.
    assign status_we = !mem_stall && idex_s && !idex_mem_read_en &&
                       !idex_mem_write_en && flag_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status <= 4'b0000;
        end else if (status_we) begin
            status <= {alu_res[MSB], (alu_res == '0), carry_out, overflow};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wb_en        <= 1'b0;
            exe_mem_read_en  <= 1'b0;
            exe_mem_write_en <= 1'b0;
            exe_alu_res      <= '0;
            exe_st_val       <= '0;
            exe_dest         <= '0;
        end else if (!mem_stall) begin
            exe_wb_en        <= idex_wb_en;
            exe_mem_read_en  <= idex_mem_read_en;
            exe_mem_write_en <= idex_mem_write_en;
            exe_alu_res      <= alu_res;
            exe_st_val       <= idex_val_rm;
            exe_dest         <= idex_dest;
        end
    end

    assign branch_offset = {{(WIDTH-26){idex_imm24[23]}}, idex_imm24, 2'b00};
    assign branch_addr   = idex_pc + branch_offset;
    assign branch_taken  = idex_b && !mem_stall;

endmodule
